// File: rtl/spi_ctrl_pkg.sv
// spi_ctrl_pkg: shared definitions for the SPI register-frame sequencer.
//   state_t      - sequencer state encoding (also exported on the debug port)
//   frame layout - RW bit 23, ADDR [22:16], DATA [15:0], MSB byte sent first
//   build_frame  - packs a command into the 24-bit frame; reads carry zero data
package spi_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_TRIG  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_HOLD  = 3'd4,
        ST_GAP   = 3'd5
    } state_t;

    localparam int FRAME_W     = 24;
    localparam int FRAME_BYTES = 3;
    localparam int RW_BIT      = 23;
    localparam int ADDR_MSB    = 22;
    localparam int ADDR_LSB    = 16;
    localparam int DATA_MSB    = 15;

    function automatic logic [FRAME_W-1:0] build_frame(input logic        rw,
                                                       input logic [6:0]  addr,
                                                       input logic [15:0] wdata);
        logic [FRAME_W-1:0] f;
        f                     = '0;
        f[RW_BIT]             = rw;
        f[ADDR_MSB:ADDR_LSB]  = addr;
        f[DATA_MSB:0]         = rw ? 16'h0000 : wdata;
        return f;
    endfunction

endpackage

// File: rtl/spi_reg_ctrl_if.sv
// spi_reg_ctrl_if: command/response side of the SPI register-frame sequencer.
//   Handshake: a command transfers on a rising clk edge where cmd_valid and
//   cmd_ready are both high; cmd_* and cfg_* must be stable while cmd_valid is
//   high. rsp_valid is a one-cycle strobe with no back-pressure; rsp_err and
//   rsp_rdata are meaningful only while it is high. busy spans accept to idle.
//   modport slave  - the sequencer
//   modport master - the register/command logic driving it
interface spi_reg_ctrl_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_rw;
    logic [6:0]  cmd_addr;
    logic [15:0] cmd_wdata;
    logic [1:0]  cfg_mode;
    logic [7:0]  cfg_frediv;
    logic        rsp_valid;
    logic        rsp_err;
    logic [15:0] rsp_rdata;
    logic        busy;

    modport slave (
        input  cmd_valid, cmd_rw, cmd_addr, cmd_wdata, cfg_mode, cfg_frediv,
        output cmd_ready, rsp_valid, rsp_err, rsp_rdata, busy
    );

    modport master (
        output cmd_valid, cmd_rw, cmd_addr, cmd_wdata, cfg_mode, cfg_frediv,
        input  cmd_ready, rsp_valid, rsp_err, rsp_rdata, busy
    );
endinterface

// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl: turns one accepted command into a 24-bit SPI register frame
// (command byte {rw,addr} then two data bytes) driven through an external
// byte-level SPI master under one frame chip-select.
//   clk, rst_n   - system clock, asynchronous active-low reset
//   cmd_if       - command/response handshake (slave modport)
//   frm_cs_n     - frame chip-select to the device pin
//   spi_mode     - {CPHA,CPOL} to the byte master, frozen per frame
//   spi_frediv   - clock divider to the byte master, frozen per frame
//   spi_trig     - one-cycle byte start pulse
//   spi_wdata    - byte to send, stable from trig until the next trig
//   spi_finish   - one-cycle byte done pulse from the byte master
//   spi_rdata    - received byte, valid with spi_finish
//   dbg_state    - current sequencer state
// All outputs come straight from flops.
module spi_reg_ctrl
    import spi_ctrl_pkg::*;
#(
    parameter int CS_SETUP    = 2,
    parameter int CS_HOLD     = 2,
    parameter int CS_GAP      = 4,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                 clk,
    input  logic                 rst_n,
    spi_reg_ctrl_if.slave        cmd_if,
    output logic                 frm_cs_n,
    output logic [1:0]           spi_mode,
    output logic [7:0]           spi_frediv,
    output logic                 spi_trig,
    output logic [7:0]           spi_wdata,
    input  logic                 spi_finish,
    input  logic [7:0]           spi_rdata,
    output state_t               dbg_state
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    // The timer counts 0..N-1, so each phase ends when it reads N-1.
    localparam logic [TW-1:0] SETUP_LAST   = TW'(CS_SETUP - 1);
    localparam logic [TW-1:0] HOLD_LAST    = TW'(CS_HOLD - 1);
    localparam logic [TW-1:0] GAP_LAST     = TW'(CS_GAP - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [1:0]    LAST_IDX     = 2'(FRAME_BYTES - 1);

    state_t               state_q, state_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic [1:0]           idx_q, idx_d;
    logic [FRAME_W-1:0]   tx_q, tx_d;
    logic [15:0]          rx_q, rx_d;
    logic                 err_q, err_d;
    logic                 cmd_ready_q, cmd_ready_d;
    logic                 busy_q, busy_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic                 rsp_err_q, rsp_err_d;
    logic [15:0]          rsp_rdata_q, rsp_rdata_d;
    logic                 cs_n_q, cs_n_d;
    logic [1:0]           spi_mode_q, spi_mode_d;
    logic [7:0]           spi_frediv_q, spi_frediv_d;
    logic                 spi_trig_q, spi_trig_d;
    logic [7:0]           spi_wdata_q, spi_wdata_d;

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        idx_d        = idx_q;
        tx_d         = tx_q;
        rx_d         = rx_q;
        err_d        = err_q;
        cmd_ready_d  = cmd_ready_q;
        busy_d       = busy_q;
        rsp_valid_d  = 1'b0;
        rsp_err_d    = rsp_err_q;
        rsp_rdata_d  = rsp_rdata_q;
        cs_n_d       = cs_n_q;
        spi_mode_d   = spi_mode_q;
        spi_frediv_d = spi_frediv_q;
        spi_trig_d   = 1'b0;
        spi_wdata_d  = spi_wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_if.cmd_valid) begin
                    tx_d         = build_frame(cmd_if.cmd_rw, cmd_if.cmd_addr, cmd_if.cmd_wdata);
                    spi_mode_d   = cmd_if.cfg_mode;
                    spi_frediv_d = cmd_if.cfg_frediv;
                    idx_d        = '0;
                    timer_d      = '0;
                    rx_d         = '0;
                    err_d        = 1'b0;
                    cmd_ready_d  = 1'b0;
                    busy_d       = 1'b1;
                    state_d      = ST_SETUP;
                end
            end
            ST_SETUP: begin
                // CS drops on the first SETUP edge, one edge after accept.
                cs_n_d = 1'b0;
                if (timer_q == SETUP_LAST) begin
                    timer_d = '0;
                    state_d = ST_TRIG;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_TRIG: begin
                spi_trig_d  = 1'b1;
                spi_wdata_d = tx_q[FRAME_W-1 -: 8];
                timer_d     = '0;
                state_d     = ST_WAIT;
            end
            ST_WAIT: begin
                // Going through TRIG (whose pulse is registered) leaves one
                // idle cycle between a finish and the next trig.
                if (spi_finish) begin
                    rx_d    = {rx_q[7:0], spi_rdata};
                    tx_d    = {tx_q[FRAME_W-9:0], 8'h00};
                    idx_d   = idx_q + 1'b1;
                    timer_d = '0;
                    state_d = (idx_q == LAST_IDX) ? ST_HOLD : ST_TRIG;
                end else if (timer_q == TIMEOUT_LAST) begin
                    err_d   = 1'b1;
                    timer_d = '0;
                    state_d = ST_HOLD;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_HOLD: begin
                if (timer_q == HOLD_LAST) begin
                    cs_n_d      = 1'b1;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = err_q;
                    rsp_rdata_d = rx_q;
                    timer_d     = '0;
                    state_d     = ST_GAP;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ST_GAP: begin
                if (timer_q == GAP_LAST) begin
                    cmd_ready_d = 1'b1;
                    busy_d      = 1'b0;
                    timer_d     = '0;
                    state_d     = ST_IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            timer_q      <= '0;
            idx_q        <= '0;
            tx_q         <= '0;
            rx_q         <= '0;
            err_q        <= 1'b0;
            cmd_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_rdata_q  <= '0;
            cs_n_q       <= 1'b1;
            spi_mode_q   <= 2'b00;
            spi_frediv_q <= 8'd1;
            spi_trig_q   <= 1'b0;
            spi_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            idx_q        <= idx_d;
            tx_q         <= tx_d;
            rx_q         <= rx_d;
            err_q        <= err_d;
            cmd_ready_q  <= cmd_ready_d;
            busy_q       <= busy_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_err_q    <= rsp_err_d;
            rsp_rdata_q  <= rsp_rdata_d;
            cs_n_q       <= cs_n_d;
            spi_mode_q   <= spi_mode_d;
            spi_frediv_q <= spi_frediv_d;
            spi_trig_q   <= spi_trig_d;
            spi_wdata_q  <= spi_wdata_d;
        end
    end

    assign cmd_if.cmd_ready = cmd_ready_q;
    assign cmd_if.busy      = busy_q;
    assign cmd_if.rsp_valid = rsp_valid_q;
    assign cmd_if.rsp_err   = rsp_err_q;
    assign cmd_if.rsp_rdata = rsp_rdata_q;
    assign frm_cs_n         = cs_n_q;
    assign spi_mode         = spi_mode_q;
    assign spi_frediv       = spi_frediv_q;
    assign spi_trig         = spi_trig_q;
    assign spi_wdata        = spi_wdata_q;
    assign dbg_state        = state_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// tb_spi_reg_ctrl: bench for spi_reg_ctrl with a behavioural byte master,
// MOSI/response scoreboards and frame timing monitors.
module tb_spi_reg_ctrl;
    import spi_ctrl_pkg::*;

    localparam int CS_SETUP = 2;
    localparam int CS_HOLD  = 2;
    localparam int CS_GAP   = 4;
    localparam int TMO      = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    spi_reg_ctrl_if cif();
    logic        frm_cs_n, spi_trig, spi_finish;
    logic [1:0]  spi_mode;
    logic [7:0]  spi_frediv, spi_wdata, spi_rdata;
    state_t      dbg_state;

    spi_reg_ctrl #(.CS_SETUP(CS_SETUP), .CS_HOLD(CS_HOLD), .CS_GAP(CS_GAP), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .cmd_if(cif),
        .frm_cs_n(frm_cs_n), .spi_mode(spi_mode), .spi_frediv(spi_frediv),
        .spi_trig(spi_trig), .spi_wdata(spi_wdata),
        .spi_finish(spi_finish), .spi_rdata(spi_rdata), .dbg_state(dbg_state)
    );

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [7:0]  exp_mosi_q[$];
    logic [16:0] exp_rsp_q[$];   // {err, rdata}
    logic [1:0]  exp_mode   = 2'b00;
    logic [7:0]  exp_frediv = 8'd1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- byte master model ----------------
    logic [7:0] miso_b[3];
    bit         bm_dead  = 0;
    bit         late_fin = 0;
    bit         bm_busy  = 0;
    int         bm_cnt   = 0;
    int         bm_idx   = 0;
    logic [7:0] bm_byte  = 8'h00;
    int         fin_cyc  = 0;

    initial begin
        spi_finish = 1'b0;
        spi_rdata  = 8'h00;
    end

    always @(negedge clk) begin
        spi_finish = 1'b0;
        if (!rst_n) begin
            bm_busy = 0;
            bm_idx  = 0;
        end else begin
            if (frm_cs_n) bm_idx = 0;
            if (bm_busy) begin
                if (bm_cnt == 0) begin
                    spi_finish = 1'b1;
                    spi_rdata  = bm_byte;
                    fin_cyc    = cyc;
                    bm_busy    = 0;
                end else begin
                    bm_cnt--;
                end
            end
            if (late_fin && dbg_state == ST_HOLD) begin
                spi_finish = 1'b1;
                spi_rdata  = 8'hFF;
                late_fin   = 0;
            end
            if (spi_trig) begin
                if (exp_mosi_q.size() == 0) check("mosi_extra", 32'(spi_wdata), 32'hDEAD);
                else check("mosi_byte", 32'(spi_wdata), 32'(exp_mosi_q.pop_front()));
                check("spi_mode_frozen", 32'(spi_mode), 32'(exp_mode));
                check("spi_frediv_frozen", 32'(spi_frediv), 32'(exp_frediv));
                if (!bm_dead) begin
                    bm_busy = 1;
                    bm_cnt  = $urandom_range(1, 6);
                    bm_byte = miso_b[bm_idx % 3];
                end
                bm_idx++;
            end
        end
    end

    // ---------------- monitors ----------------
    int  gap_cnt = 100;
    int  setup_cnt = 0;
    bit  first_trig = 0;
    bit  cs_prev = 1;
    int  trig_cyc = 0;
    int  n_trig = 0;
    int  n_rsp = 0;
    logic [16:0] e;

    always @(negedge clk) begin
        if (!rst_n) begin
            cs_prev = 1;
            gap_cnt = 100;
            first_trig = 0;
        end else begin
            if (frm_cs_n) gap_cnt++;
            else begin
                if (cs_prev) begin
                    check("cs_gap_min", 32'(gap_cnt >= CS_GAP), 32'd1);
                    setup_cnt  = 0;
                    first_trig = 1;
                end else setup_cnt++;
                gap_cnt = 0;
            end
            if (spi_trig) begin
                check("cs_low_at_trig", 32'(frm_cs_n), 32'd0);
                if (first_trig) begin
                    check("cs_setup", 32'(setup_cnt), 32'(CS_SETUP));
                    first_trig = 0;
                end
                trig_cyc = cyc;
                n_trig++;
            end
            if (cif.rsp_valid) begin
                n_rsp++;
                check("cs_rise_with_rsp", 32'({cs_prev, frm_cs_n}), 32'b01);
                if (exp_rsp_q.size() == 0) check("rsp_extra", 32'(cif.rsp_rdata), 32'hDEAD);
                else begin
                    e = exp_rsp_q.pop_front();
                    check("rsp_err", 32'(cif.rsp_err), 32'(e[16]));
                    check("rsp_rdata", 32'(cif.rsp_rdata), 32'(e[15:0]));
                    if (e[16]) check("rsp_timeout_lat", 32'(cyc - trig_cyc), 32'(TMO + CS_HOLD));
                    else       check("rsp_hold_lat", 32'(cyc - fin_cyc), 32'(CS_HOLD + 1));
                end
            end
            if (cif.cmd_valid && cif.cmd_ready)
                check("accept_in_idle", 32'(dbg_state == ST_IDLE && !cif.busy), 32'd1);
            cs_prev = frm_cs_n;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_exp(input bit rw, input logic [6:0] addr, input logic [15:0] wd,
                            input logic [7:0] m0, input logic [7:0] m1, input logic [7:0] m2,
                            input bit tmo);
        exp_mosi_q.push_back({rw, addr});
        if (!tmo) begin
            exp_mosi_q.push_back(rw ? 8'h00 : wd[15:8]);
            exp_mosi_q.push_back(rw ? 8'h00 : wd[7:0]);
        end
        miso_b[0] = m0;
        miso_b[1] = m1;
        miso_b[2] = m2;
        exp_rsp_q.push_back(tmo ? {1'b1, 16'h0000} : {1'b0, m1, m2});
    endtask

    task automatic wait_ready();
        int i;
        for (i = 0; i < 300 && !cif.cmd_ready; i++) @(negedge clk);
        if (!cif.cmd_ready) check("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_cmd(input bit rw, input logic [6:0] addr, input logic [15:0] wd,
                            input logic [1:0] mode, input logic [7:0] div,
                            input logic [7:0] m0, input logic [7:0] m1, input logic [7:0] m2,
                            input bit tmo);
        wait_ready();
        push_exp(rw, addr, wd, m0, m1, m2, tmo);
        exp_mode       = mode;
        exp_frediv     = div;
        cif.cmd_rw     = rw;
        cif.cmd_addr   = addr;
        cif.cmd_wdata  = wd;
        cif.cfg_mode   = mode;
        cif.cfg_frediv = div;
        cif.cmd_valid  = 1'b1;
        @(negedge clk);
        cif.cmd_valid  = 1'b0;
        // Reprogram the config mid-frame; the frame must keep the latched values.
        cif.cfg_mode   = ~mode;
        cif.cfg_frediv = ~div;
    endtask

    task automatic wait_done();
        int i;
        for (i = 0; i < 600 && !(exp_rsp_q.size() == 0 && cif.cmd_ready); i++) @(negedge clk);
        check("frame_done_timeout", 32'(exp_rsp_q.size() == 0 && cif.cmd_ready), 32'd1);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not end, cycle %0d", cyc);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
        $fatal(1);
    end

    // ---------------- main sequence ----------------
    initial begin
        int base, acc;
        cif.cmd_valid = 1'b0; cif.cmd_rw = 1'b0; cif.cmd_addr = '0; cif.cmd_wdata = '0;
        cif.cfg_mode = 2'b00; cif.cfg_frediv = 8'd1;
        repeat (3) @(negedge clk);
        check("rst_cmd_ready", 32'(cif.cmd_ready), 32'd1);
        check("rst_cs_n", 32'(frm_cs_n), 32'd1);
        check("rst_spi_mode", 32'(spi_mode), 32'd0);
        check("rst_spi_frediv", 32'(spi_frediv), 32'd1);
        check("rst_outputs_zero", 32'({spi_trig, spi_wdata, cif.rsp_valid, cif.rsp_err, cif.rsp_rdata, cif.busy}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Write frame
        send_cmd(1'b0, 7'h15, 16'hA5C3, 2'd0, 8'd4, 8'h11, 8'h22, 8'h33, 1'b0);
        check("busy_after_accept", 32'(cif.busy), 32'd1);
        wait_done();

        // Read frame in all four modes, random divider
        for (int m = 0; m < 4; m++) begin
            send_cmd(1'b1, 7'h2A, 16'($urandom), 2'(m), 8'($urandom_range(1, 255)), 8'h00, 8'hBE, 8'hEF, 1'b0);
            wait_done();
        end

        // Random frames
        for (int k = 0; k < 4; k++) begin
            send_cmd(1'($urandom), 7'($urandom), 16'($urandom), 2'($urandom), 8'($urandom),
                     8'($urandom), 8'($urandom), 8'($urandom), 1'b0);
            wait_done();
        end

        // Timeout with a dead byte master and a late finish during HOLD
        bm_dead  = 1;
        late_fin = 1;
        base     = n_rsp;
        send_cmd(1'b1, 7'h33, 16'h0000, 2'd1, 8'd2, 8'h00, 8'h12, 8'h34, 1'b1);
        wait_done();
        repeat (10) @(negedge clk);
        check("timeout_single_rsp", 32'(n_rsp - base), 32'd1);
        check("timeout_late_fin_used", 32'(late_fin), 32'd0);
        check("timeout_cs_high", 32'(frm_cs_n), 32'd1);
        bm_dead = 0;
        send_cmd(1'b0, 7'h01, 16'h5A5A, 2'd2, 8'd3, 8'h01, 8'h02, 8'h03, 1'b0);
        wait_done();

        // Back-to-back commands with cmd_valid held high
        base = n_rsp;
        wait_ready();
        for (int k = 0; k < 3; k++) push_exp(1'b1, 7'h44, 16'h0000, 8'h00, 8'hC0, 8'hDE, 1'b0);
        exp_mode = 2'd3; exp_frediv = 8'd6;
        cif.cmd_rw = 1'b1; cif.cmd_addr = 7'h44; cif.cmd_wdata = 16'h0000;
        cif.cfg_mode = 2'd3; cif.cfg_frediv = 8'd6;
        cif.cmd_valid = 1'b1;
        acc = 0;
        for (int i = 0; i < 2000 && acc < 3; i++) begin
            if (cif.cmd_ready) acc++;
            @(negedge clk);
        end
        cif.cmd_valid = 1'b0;
        check("b2b_accepts", 32'(acc), 32'd3);
        wait_done();
        check("b2b_rsp_count", 32'(n_rsp - base), 32'd3);

        // Reset during byte 1
        base = n_trig;
        send_cmd(1'b0, 7'h22, 16'h1234, 2'd0, 8'd8, 8'h00, 8'h00, 8'h00, 1'b0);
        for (int i = 0; i < 200 && n_trig < base + 2; i++) @(negedge clk);
        check("reset_reached_byte1", 32'(n_trig - base), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        check("reset_cs_n_async", 32'(frm_cs_n), 32'd1);
        check("reset_busy_async", 32'(cif.busy), 32'd0);
        exp_mosi_q.delete();
        exp_rsp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        exp_frediv = 8'd1;
        send_cmd(1'b0, 7'h7F, 16'hCAFE, 2'd1, 8'd5, 8'h0A, 8'h0B, 8'h0C, 1'b0);
        wait_done();

        repeat (5) @(negedge clk);
        check("mosi_queue_drained", 32'(exp_mosi_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
